// File: rtl/fsk_pkg.sv
// Shared constants, state encoding and NCO tuning words for the 16-tone FSK modulator.
package fsk_pkg;

  localparam longint FS_HZ    = 100_000_000;
  localparam int     PHASE_W  = 32;
  localparam int     LUT_AW   = 10;
  localparam int     SAMPLE_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA
  } state_t;

  // Tone k sits at (k+1) MHz; FTW = round(f * 2^PHASE_W / FS_HZ), exact integer arithmetic.
  function automatic logic [PHASE_W-1:0] ftw_calc(int k);
    longint num;
    num = longint'(k + 1) * 64'sd1_000_000 * (64'sd1 <<< PHASE_W);
    return PHASE_W'((num + FS_HZ / 2) / FS_HZ);
  endfunction

  localparam logic [PHASE_W-1:0] FTW [16] = '{
    ftw_calc(0),  ftw_calc(1),  ftw_calc(2),  ftw_calc(3),
    ftw_calc(4),  ftw_calc(5),  ftw_calc(6),  ftw_calc(7),
    ftw_calc(8),  ftw_calc(9),  ftw_calc(10), ftw_calc(11),
    ftw_calc(12), ftw_calc(13), ftw_calc(14), ftw_calc(15)
  };

endpackage

// File: rtl/fsk_sin_lut.sv
// 1024-point AMP-scaled sine built from a 256-entry quarter-wave table by symmetry folding.
module fsk_sin_lut
  import fsk_pkg::*;
#(
  parameter int AMP = 131071
) (
  input  logic [LUT_AW-1:0]          idx,
  output logic signed [SAMPLE_W-1:0] sample
);

  localparam int  QN = 2 ** (LUT_AW - 2);
  localparam real PI = 3.14159265358979323846;

  logic signed [SAMPLE_W-1:0] qtab [QN];

  for (genvar i = 0; i < QN; i++) begin : g_qtab
    localparam int V = $rtoi(AMP * $sin(2.0 * PI * i / (4.0 * QN)) + 0.5);
    assign qtab[i] = SAMPLE_W'(V);
  end

  logic [1:0]                 quad;
  logic [LUT_AW-3:0]          addr;
  logic [LUT_AW-3:0]          mir;
  logic signed [SAMPLE_W-1:0] mag;

  // Odd quadrants read the table mirrored; the peak (mirror of 0) is not stored.
  always_comb begin
    quad = idx[LUT_AW-1 -: 2];
    addr = idx[LUT_AW-3:0];
    mir  = -addr;
    if (quad[0]) mag = (addr == '0) ? SAMPLE_W'(AMP) : qtab[mir];
    else         mag = qtab[addr];
    sample = quad[1] ? -mag : mag;
  end

endmodule

// File: rtl/fsk_modulator.sv
// 16-tone FSK modulator: preamble, then NCO-driven sin/cos symbols with registered outputs.
// Define FSK_MOD_BURST_EN to return to IDLE on underrun instead of padding with symbol 0.
module fsk_modulator
  import fsk_pkg::*;
#(
  parameter int                 SYM_LEN    = 100,
  parameter int                 SYNC_LEN   = 9,
  parameter logic signed [17:0] SYNC_LEVEL = 18'sd100,
  parameter int                 AMP        = 131071
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic signed [17:0] dac_out_sin,
  output logic signed [17:0] dac_out_cos,
  output logic               sym_start,
  output logic               underrun
);

  localparam int CNT_MAX = (SYM_LEN > SYNC_LEN) ? SYM_LEN : SYNC_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                     state, state_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic [3:0]                 sym, sym_n;
  logic [PHASE_W-1:0]         phase, phase_n;
  logic                       ready_n, sym_start_n, underrun_n;
  logic signed [17:0]         sin_n, cos_n, lut_sin, lut_cos;
  logic [LUT_AW-1:0]          lut_idx;
  logic                       xfer, last_sync, last_sym;

  assign xfer      = data_valid && data_ready;
  assign last_sync = (cnt == CNT_W'(SYNC_LEN - 1));
  assign last_sym  = (cnt == CNT_W'(SYM_LEN - 1));

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sym_n      = sym;
    phase_n    = phase;
    underrun_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          state_n = SYNC;
          cnt_n   = '0;
          sym_n   = data_in;
        end
      end
      SYNC: begin
        if (last_sync) begin
          state_n = DATA;
          cnt_n   = '0;
          phase_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (last_sym) begin
          cnt_n   = '0;
          phase_n = '0;
          if (xfer) begin
            sym_n = data_in;
          end else begin
            underrun_n = 1'b1;
`ifdef FSK_MOD_BURST_EN
            state_n = IDLE;
`else
            sym_n = '0;
`endif
          end
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          phase_n = phase + FTW[sym];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Lookup runs on the next phase so the registered sample lines up with the counter.
  assign lut_idx = phase_n[PHASE_W-1 -: LUT_AW];

  fsk_sin_lut #(.AMP(AMP)) u_sin_lut (
    .idx    (lut_idx),
    .sample (lut_sin)
  );

  fsk_sin_lut #(.AMP(AMP)) u_cos_lut (
    .idx    (lut_idx + LUT_AW'(256)),
    .sample (lut_cos)
  );

  always_comb begin
    ready_n     = (state_n == IDLE) || ((state_n == DATA) && (cnt_n == CNT_W'(SYM_LEN - 1)));
    sym_start_n = (state_n == DATA) && (cnt_n == '0);
    sin_n       = '0;
    cos_n       = '0;
    if (state_n == SYNC) begin
      sin_n = SYNC_LEVEL;
    end else if (state_n == DATA) begin
      sin_n = lut_sin;
      cos_n = lut_cos;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sym         <= '0;
      phase       <= '0;
      data_ready  <= 1'b0;
      sym_start   <= 1'b0;
      underrun    <= 1'b0;
      dac_out_sin <= '0;
      dac_out_cos <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sym         <= sym_n;
      phase       <= phase_n;
      data_ready  <= ready_n;
      sym_start   <= sym_start_n;
      underrun    <= underrun_n;
      dac_out_sin <= sin_n;
      dac_out_cos <= cos_n;
    end
  end

endmodule
